// File: rtl/ast_width_pkg.sv
// rtl/ast_width_pkg.sv - shared types and beat arithmetic for the Avalon-ST width reducer
package ast_width_pkg;

    // EMPTY: holding register free; SEND: holding register drains beats
    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } ast_wr_state_t;

    // Number of narrow beats needed to carry valid_bytes bytes
    function automatic int beats_for(input int valid_bytes, input int out_bytes);
        return (valid_bytes + out_bytes - 1) / out_bytes;
    endfunction

    // Unused bytes left over in the final beat of a word
    function automatic int last_empty(input int n, input int out_bytes, input int valid_bytes);
        return n * out_bytes - valid_bytes;
    endfunction

endpackage

// File: rtl/ast_width_reducer.sv
// rtl/ast_width_reducer.sv - splits wide Avalon-ST words into a sequence of narrow beats
module ast_width_reducer
    import ast_width_pkg::*;
#(
    parameter int DATA_IN_W   = 64,
    parameter int EMPTY_IN_W  = 3,
    parameter int CHANNEL_W   = 10,
    parameter int DATA_OUT_W  = 16,
    parameter int EMPTY_OUT_W = 1
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [DATA_IN_W-1:0]   snk_data,
    input  logic                   snk_startofpacket,
    input  logic                   snk_endofpacket,
    input  logic                   snk_valid,
    input  logic [EMPTY_IN_W-1:0]  snk_empty,
    input  logic [CHANNEL_W-1:0]   snk_channel,
    output logic                   snk_ready,
    output logic [DATA_OUT_W-1:0]  src_data,
    output logic                   src_startofpacket,
    output logic                   src_endofpacket,
    output logic                   src_valid,
    output logic [EMPTY_OUT_W-1:0] src_empty,
    output logic [CHANNEL_W-1:0]   src_channel,
    input  logic                   src_ready
);

    localparam int R  = DATA_IN_W / DATA_OUT_W;
    localparam int IB = DATA_IN_W / 8;
    localparam int OB = DATA_OUT_W / 8;
    localparam int IW = $clog2(R);
    localparam int NW = IW + 1;

    ast_wr_state_t          state;
    ast_wr_state_t          state_next;
    logic [IW-1:0]          idx;
    logic [NW-1:0]          n_beats;
    logic [DATA_IN_W-1:0]   word;
    logic                   hold_sop;
    logic                   hold_eop;
    logic [CHANNEL_W-1:0]   hold_chan;
    logic [EMPTY_OUT_W-1:0] hold_last_empty;

    logic                   last_beat;
    logic                   snk_xfer;
    logic                   src_xfer;
    int                     load_v;
    int                     load_nb;
    int                     load_le;
    logic [NW-1:0]          load_n;
    logic [EMPTY_OUT_W-1:0] load_empty;

    assign last_beat = ({1'b0, idx} == (n_beats - NW'(1)));
    assign src_valid = (state == SEND);
    assign src_xfer  = src_valid && src_ready;
    assign snk_xfer  = snk_valid && snk_ready;

    // Beat count and final-beat empty for the word currently on the sink;
    // empty only matters on an eop word, otherwise the full word is sent
    always_comb begin
        load_v     = IB - int'(snk_empty);
        load_nb    = beats_for(load_v, OB);
        load_le    = last_empty(load_nb, OB, load_v);
        load_n     = NW'(R);
        load_empty = '0;
        if (snk_endofpacket) begin
            load_n     = NW'(load_nb);
            load_empty = EMPTY_OUT_W'(load_le);
        end
    end

    // Next state and sink ready; the sink may refill on the cycle the last beat leaves
    always_comb begin
        state_next = state;
        snk_ready  = 1'b0;
        case (state)
            EMPTY: begin
                snk_ready = !srst;
                if (snk_xfer) state_next = SEND;
            end
            SEND: begin
                snk_ready = !srst && last_beat && src_ready;
                if (src_xfer && last_beat) state_next = snk_xfer ? SEND : EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    // State register and holding register; the held word shifts up one beat per transfer
    always_ff @(posedge clk) begin
        if (srst) begin
            state           <= EMPTY;
            idx             <= '0;
            n_beats         <= '0;
            word            <= '0;
            hold_sop        <= 1'b0;
            hold_eop        <= 1'b0;
            hold_chan       <= '0;
            hold_last_empty <= '0;
        end else begin
            state <= state_next;
            if (snk_xfer) begin
                idx             <= '0;
                n_beats         <= load_n;
                word            <= snk_data;
                hold_sop        <= snk_startofpacket;
                hold_eop        <= snk_endofpacket;
                hold_chan       <= snk_channel;
                hold_last_empty <= load_empty;
            end else if (src_xfer) begin
                idx  <= last_beat ? '0 : idx + IW'(1);
                word <= word << DATA_OUT_W;
            end
        end
    end

    // Source outputs are forced to zero whenever no beat is presented
    always_comb begin
        src_data          = src_valid ? word[DATA_IN_W-1 -: DATA_OUT_W] : '0;
        src_startofpacket = src_valid && hold_sop && (idx == '0);
        src_endofpacket   = src_valid && hold_eop && last_beat;
        src_empty         = src_endofpacket ? hold_last_empty : '0;
        src_channel       = src_valid ? hold_chan : '0;
    end

endmodule

// File: tb/tb_ast_width_reducer.sv
// tb/tb_ast_width_reducer.sv - randomized self-checking bench for ast_width_reducer
interface ast_wr_if #(
    parameter int DATA_IN_W   = 64,
    parameter int EMPTY_IN_W  = 3,
    parameter int CHANNEL_W   = 10,
    parameter int DATA_OUT_W  = 16,
    parameter int EMPTY_OUT_W = 1
) (
    input logic clk
);
    logic                   srst;
    logic [DATA_IN_W-1:0]   snk_data;
    logic                   snk_startofpacket;
    logic                   snk_endofpacket;
    logic                   snk_valid;
    logic [EMPTY_IN_W-1:0]  snk_empty;
    logic [CHANNEL_W-1:0]   snk_channel;
    logic                   snk_ready;
    logic [DATA_OUT_W-1:0]  src_data;
    logic                   src_startofpacket;
    logic                   src_endofpacket;
    logic                   src_valid;
    logic [EMPTY_OUT_W-1:0] src_empty;
    logic [CHANNEL_W-1:0]   src_channel;
    logic                   src_ready;

    modport gen (input clk, output srst, snk_data, snk_startofpacket, snk_endofpacket,
                 snk_valid, snk_empty, snk_channel, src_ready,
                 input snk_ready, src_data, src_startofpacket, src_endofpacket,
                 src_valid, src_empty, src_channel);
    modport mon (input clk, srst, snk_data, snk_startofpacket, snk_endofpacket, snk_valid,
                 snk_empty, snk_channel, snk_ready, src_data, src_startofpacket,
                 src_endofpacket, src_valid, src_empty, src_channel, src_ready);
endinterface

module tb_ast_width_reducer;

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
        logic [0:0]  empty;
        logic [9:0]  chan;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    ast_wr_if bus (.clk(clk));

    ast_width_reducer dut (
        .clk               (clk),
        .srst              (bus.srst),
        .snk_data          (bus.snk_data),
        .snk_startofpacket (bus.snk_startofpacket),
        .snk_endofpacket   (bus.snk_endofpacket),
        .snk_valid         (bus.snk_valid),
        .snk_empty         (bus.snk_empty),
        .snk_channel       (bus.snk_channel),
        .snk_ready         (bus.snk_ready),
        .src_data          (bus.src_data),
        .src_startofpacket (bus.src_startofpacket),
        .src_endofpacket   (bus.src_endofpacket),
        .src_valid         (bus.src_valid),
        .src_empty         (bus.src_empty),
        .src_channel       (bus.src_channel),
        .src_ready         (bus.src_ready)
    );

    beat_t model_q[$];
    beat_t seen[$];
    int    seen_cyc[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    armed = 1'b0;
    int    ready_mode = 0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected beats of one accepted word, straight from the byte-count rules
    task automatic push_word(input logic [63:0] w, input logic sop, input logic eop,
                             input logic [2:0] emp, input logic [9:0] ch);
        int v;
        int n;
        beat_t x;
        v = eop ? 8 - int'(emp) : 8;
        n = (v + 1) / 2;
        for (int b = 0; b < n; b++) begin
            x.data  = w[63 - 16*b -: 16];
            x.sop   = sop && (b == 0);
            x.eop   = eop && (b == n - 1);
            x.empty = (eop && b == n - 1) ? 1'(2*n - v) : 1'b0;
            x.chan  = ch;
            model_q.push_back(x);
        end
    endtask

    // Passive monitor and compare process, sampling mid-cycle
    always @(negedge clk) begin
        beat_t cur;
        beat_t exp;
        logic [15:0] mask;
        logic exp_rdy;
        cyc++;
        if (armed) begin
            cur = {bus.src_data, bus.src_startofpacket, bus.src_endofpacket,
                   bus.src_empty, bus.src_channel};
            chk("src_valid", 64'(bus.src_valid), 64'(model_q.size() > 0));
            exp_rdy = !bus.srst && (model_q.size() == 0 ||
                                    (model_q.size() == 1 && bus.src_ready));
            chk("snk_ready", 64'(bus.snk_ready), 64'(exp_rdy));
            if (bus.src_valid && model_q.size() > 0) begin
                exp  = model_q[0];
                mask = exp.empty ? 16'hFF00 : 16'hFFFF;
                chk("src_data", 64'(cur.data & mask), 64'(exp.data & mask));
                chk("src_sop", 64'(cur.sop), 64'(exp.sop));
                chk("src_eop", 64'(cur.eop), 64'(exp.eop));
                chk("src_empty", 64'(cur.empty), 64'(exp.empty));
                chk("src_channel", 64'(cur.chan), 64'(exp.chan));
            end
            if (prev_stall) chk("stall_hold", 64'(cur), 64'(prev_beat));
            prev_stall = bus.src_valid && !bus.src_ready && !bus.srst;
            prev_beat  = cur;
            if (bus.srst) begin
                model_q.delete();
            end else begin
                if (bus.src_valid && bus.src_ready) begin
                    if (model_q.size() > 0) void'(model_q.pop_front());
                    seen.push_back(cur);
                    seen_cyc.push_back(cyc);
                end
                if (bus.snk_valid && bus.snk_ready)
                    push_word(bus.snk_data, bus.snk_startofpacket, bus.snk_endofpacket,
                              bus.snk_empty, bus.snk_channel);
            end
        end
    end

    // Downstream ready generator
    initial begin
        bus.src_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.src_ready = 1'b1;
                1:       bus.src_ready = ~bus.src_ready;
                2:       bus.src_ready = ($urandom_range(0, 9) < 7);
                default: bus.src_ready = 1'b0;
            endcase
        end
    end

    // Presents one word; called and returns just after a rising edge
    task automatic send_word(input logic [63:0] w, input logic sop, input logic eop,
                             input logic [2:0] emp, input logic [9:0] ch);
        bus.snk_data          = w;
        bus.snk_startofpacket = sop;
        bus.snk_endofpacket   = eop;
        bus.snk_empty         = emp;
        bus.snk_channel       = ch;
        bus.snk_valid         = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.snk_ready) begin
                @(posedge clk);
                #1;
                bus.snk_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus.snk_valid = 1'b0;
    endtask

    task automatic wait_seen(input int n);
        for (int t = 0; t < 300; t++) begin
            if (seen.size() >= n) return;
            @(posedge clk);
            #1;
        end
        chk("wait_seen_timeout", 64'(seen.size()), 64'(n));
        $fatal(1, "FAIL wait_seen_timeout: beats never arrived");
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 2000; t++) begin
            if (model_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain", 64'(model_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        int len;
        logic [9:0] ch;
        logic [63:0] w;
        logic [63:0] w4 [3];
        bus.srst = 1'b1;
        bus.snk_data = '0;
        bus.snk_startofpacket = 1'b0;
        bus.snk_endofpacket = 1'b0;
        bus.snk_valid = 1'b0;
        bus.snk_empty = '0;
        bus.snk_channel = '0;
        repeat (3) @(posedge clk);
        #1 armed = 1'b1;
        @(posedge clk);
        #1 bus.srst = 1'b0;
        @(negedge clk);
        chk("rst_src_valid", 64'(bus.src_valid), 64'd0);
        chk("rst_src_data", 64'(bus.src_data), 64'd0);
        chk("rst_src_sop", 64'(bus.src_startofpacket), 64'd0);
        chk("rst_src_eop", 64'(bus.src_endofpacket), 64'd0);
        chk("rst_src_empty", 64'(bus.src_empty), 64'd0);
        chk("rst_src_channel", 64'(bus.src_channel), 64'd0);
        chk("rst_snk_ready", 64'(bus.snk_ready), 64'd1);
        @(posedge clk);
        #1;

        // Full word, single-word packet
        base = seen.size();
        send_word(64'h1122334455667788, 1'b1, 1'b1, 3'd0, 10'd5);
        wait_seen(base + 4);
        chk("t1_b0", 64'(seen[base].data), 64'h1122);
        chk("t1_b1", 64'(seen[base+1].data), 64'h3344);
        chk("t1_b2", 64'(seen[base+2].data), 64'h5566);
        chk("t1_b3", 64'(seen[base+3].data), 64'h7788);
        chk("t1_sop", 64'({seen[base].sop, seen[base+1].sop}), 64'b10);
        chk("t1_eop", 64'({seen[base+2].eop, seen[base+3].eop}), 64'b01);
        chk("t1_empty", 64'(seen[base+3].empty), 64'd0);
        chk("t1_chan", 64'(seen[base+2].chan), 64'd5);

        // Five valid bytes: three beats, last one half used
        base = seen.size();
        send_word(64'h1122334455667788, 1'b1, 1'b1, 3'd3, 10'd5);
        wait_seen(base + 3);
        chk("t2_b0", 64'(seen[base].data), 64'h1122);
        chk("t2_b1", 64'(seen[base+1].data), 64'h3344);
        chk("t2_b2_hi", 64'(seen[base+2].data[15:8]), 64'h55);
        chk("t2_eop", 64'({seen[base+1].eop, seen[base+2].eop}), 64'b01);
        chk("t2_empty", 64'(seen[base+2].empty), 64'd1);

        // One valid byte: a single beat carrying sop and eop
        base = seen.size();
        send_word(64'h1122334455667788, 1'b1, 1'b1, 3'd7, 10'd9);
        wait_seen(base + 1);
        chk("t3_hi", 64'(seen[base].data[15:8]), 64'h11);
        chk("t3_flags", 64'({seen[base].sop, seen[base].eop, seen[base].empty}), 64'b111);
        @(negedge clk);
        chk("t3_snk_ready", 64'(bus.snk_ready), 64'd1);
        @(posedge clk);
        #1;

        // Three-word packet under alternating backpressure
        ready_mode = 1;
        base = seen.size();
        w4[0] = 64'h0102030405060708;
        w4[1] = 64'h1112131415161718;
        w4[2] = 64'h2122232425262728;
        for (int j = 0; j < 3; j++) send_word(w4[j], j == 0, j == 2, 3'd0, 10'd3);
        wait_seen(base + 12);
        wait_idle();
        chk("t4_count", 64'(seen.size() - base), 64'd12);
        chk("t4_first", 64'(seen[base].data), 64'h0102);
        chk("t4_mid", 64'(seen[base+5].data), 64'h1314);
        chk("t4_last", 64'(seen[base+11].data), 64'h2728);
        chk("t4_eop", 64'(seen[base+11].eop), 64'd1);

        // Back-to-back words with the source always ready
        ready_mode = 0;
        @(posedge clk);
        #1;
        base = seen.size();
        for (int j = 0; j < 4; j++)
            send_word({$urandom, $urandom}, j == 0, j == 3, 3'd0, 10'd7);
        wait_seen(base + 16);
        chk("t5_span", 64'(seen_cyc[base+15] - seen_cyc[base]), 64'd15);

        // Reset while beat 2 is still waiting
        base = seen.size();
        send_word(64'hCAFE0000BEEF1111, 1'b1, 1'b1, 3'd0, 10'd1);
        wait_seen(base + 2);
        ready_mode = 3;
        bus.srst = 1'b1;
        @(posedge clk);
        #1 bus.srst = 1'b0;
        @(negedge clk);
        chk("t6_valid_after_rst", 64'(bus.src_valid), 64'd0);
        @(posedge clk);
        #1 ready_mode = 0;
        base = seen.size();
        send_word(64'hA1A2B1B2C1C2D1D2, 1'b1, 1'b1, 3'd0, 10'd2);
        wait_seen(base + 4);
        chk("t6_b0", 64'(seen[base].data), 64'hA1A2);
        chk("t6_sop", 64'(seen[base].sop), 64'd1);
        chk("t6_b3", 64'(seen[base+3].data), 64'hD1D2);

        // Random packets, random gaps, random backpressure
        ready_mode = 2;
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(1, 4);
            ch  = 10'($urandom);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) @(posedge clk);
                    #1;
                end
                w = {$urandom, $urandom};
                send_word(w, j == 0, j == len - 1, 3'($urandom_range(0, 7)), ch);
            end
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ast_width_reducer.md
# ast_width_reducer

Avalon-ST width reducer: accepts wide words on a sink port and emits them as a sequence of narrower beats on a source port. Preserves packet framing, channel and empty. It is the counterpart of the team's width extender, and sits where a wide internal datapath must feed a narrow streaming consumer. The bench reuses the extender's verification style: a generator drives the sink and `src_ready`, and a passive monitor observes both ports.

## Interface
- `DATA_IN_W`, 64: sink data width, bits. Multiple of 8.
- `EMPTY_IN_W`, 3: sink empty width. Equals `$clog2(DATA_IN_W/8)`.
- `CHANNEL_W`, 10: channel width. Passed through unchanged.
- `DATA_OUT_W`, 16: source data width, bits. Multiple of 8. `DATA_IN_W/DATA_OUT_W` is a power of 2 and ≥ 2.
- `EMPTY_OUT_W`, 1: source empty width. Equals `max(1, $clog2(DATA_OUT_W/8))`.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `srst` input 1: reset, synchronous, active-high.
- `snk_data` input DATA_IN_W: wide word. First symbol is in the MSBs.
- `snk_startofpacket` input 1: first word of packet.
- `snk_endofpacket` input 1: last word of packet.
- `snk_valid` input 1: sink word valid.
- `snk_empty` input EMPTY_IN_W: unused bytes in the word, counted from the LSB end. Meaningful only with `snk_endofpacket`.
- `snk_channel` input CHANNEL_W: channel of the word.
- `snk_ready` output 1: sink ready.
- `src_data` output DATA_OUT_W: narrow beat.
- `src_startofpacket` output 1: first beat of packet.
- `src_endofpacket` output 1: last beat of packet.
- `src_valid` output 1: source beat valid.
- `src_empty` output EMPTY_OUT_W: unused bytes in the beat. Nonzero only with `src_endofpacket`.
- `src_channel` output CHANNEL_W: channel of the beat.
- `src_ready` input 1: downstream ready.

## Operation
- Derived constants: R = DATA_IN_W/DATA_OUT_W; IB = DATA_IN_W/8; OB = DATA_OUT_W/8.
- Handshake rules:
  - A transfer occurs on a cycle where valid && ready. Ready latency is 0.
  - The source never withdraws `src_valid` once asserted.
  - While `src_valid && !src_ready`, all `src_*` outputs are held stable.
- Holding register: one wide word plus its sop, eop, channel and beat count N.
- N computation:
  - Word not carrying eop: N = R, and `snk_empty` is ignored.
  - Word carrying eop: V = IB − `snk_empty`, which is ≥ 1 by range; N = ceil(V/OB).
- States:
  - EMPTY: `src_valid`=0, `snk_ready`=1. A sink transfer loads the register → SEND, beat index i=0.
  - SEND: `src_valid`=1 and `src_data` = word[DATA_IN_W−1−i·DATA_OUT_W −: DATA_OUT_W].
    - A source transfer with i<N−1 increments i.
    - A source transfer with i=N−1 is the last beat. With a simultaneous sink transfer, reload and go to i=0; otherwise → EMPTY.
- `snk_ready` = EMPTY || (SEND && i==N−1 && `src_ready`). This is a combinational path from `src_ready` to `snk_ready`, and it is accepted.
- Framing outputs:
  - `src_startofpacket` = stored sop && i==0.
  - `src_endofpacket` = stored eop && i==N−1.
  - `src_empty` = N·OB − V on the eop beat, 0 otherwise.
  - `src_channel` = stored channel on every beat of the word.
- Bytes beyond V in the final beat are don't-care.
- A word with both sop and eop is a complete packet; a single beat is possible, carrying both sop and eop.
- Framing errors (missing sop or eop) are not checked; framing passes through as received.

## Timing
- During and after `srst`:
  - State → EMPTY, i=0.
  - `src_valid`=0, `src_startofpacket`=0, `src_endofpacket`=0, `src_empty`=0, `src_data`=0, `src_channel`=0.
  - `snk_ready`=0 while `srst`=1, and 1 on the first cycle after.
- Latency: a word accepted at edge k presents beat 0 from cycle k+1.
- Throughput: with `src_ready` held at 1, each word yields N consecutive source beats with no bubble between words.
- Reset mid-word: the held word is discarded, and `src_valid`=0 from the next cycle.
- `srst` has priority over any simultaneous transfer.

## Structure
- Package `ast_width_pkg` contains:
  - typedef `ast_wr_state_t` with values EMPTY and SEND;
  - function `beats_for(valid_bytes, out_bytes)`, which returns the ceiling division;
  - function `last_empty(n, out_bytes, valid_bytes)`.
- No RTL sub-module.
- The bench uses interface `ast_wr_if`, which has the same signal set as the extender's bench interface, plus generator and monitor modports.
- Target size: about 150 lines of RTL.

## Test plan
All scenarios use the default parameters, so R=4, IB=8, OB=2.
1. Word 0x1122334455667788 with sop+eop, empty=0, channel=5, `src_ready`=1 → beats 0x1122, 0x3344, 0x5566, 0x7788; sop on beat 0, eop on beat 3, `src_empty`=0, channel 5 on all beats; `snk_ready` low for 3 cycles.
2. Same word with empty=3 (V=5) → beats 0x1122, 0x3344, 0x55xx; eop and `src_empty`=1 on the 3rd beat; `snk_ready` returns after 3 beats.
3. Empty=7 (V=1) with sop+eop → one beat 0x11xx carrying sop, eop and `src_empty`=1; `snk_ready` stays high.
4. Three-word packet with `src_ready` pattern 1,0,1,0,… → 12 beats in order with no loss or duplication; `src_*` held stable on every stalled cycle.
5. Back-to-back words, `src_valid` and `src_ready` high throughout → `src_valid` continuously high, one sink transfer every 4 cycles, coinciding with the last beat.
6. `srst` pulsed while beat 2 of a word is pending → `src_valid`=0 on the next cycle; the next packet is emitted correctly from beat 0.
